// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single physical memory port between the I-cache (line reads)
// and the D-cache (line reads and writebacks). It grants one client at a
// time and latches that client's address, write data and operation. It then
// runs exactly one memory transaction and returns the completion to the
// granted client only.
//
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority, D-cache over I-cache.
//   defined   : when both clients request in the same cycle, the client that
//               was not granted last time wins (last_grant resets to D).
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   i_read        : I-cache line read request (level, held until i_resp)
//   i_address     : I-cache line address
//   i_rdata       : line data to I-cache (follows pmem_rdata)
//   i_resp        : completion pulse to I-cache, same cycle as pmem_resp
//   d_read        : D-cache line read request (level, held until d_resp)
//   d_write       : D-cache writeback request (level, held until d_resp)
//   d_address     : D-cache line address
//   d_wdata       : D-cache writeback data
//   d_rdata       : line data to D-cache (follows pmem_rdata)
//   d_resp        : completion pulse to D-cache, same cycle as pmem_resp
//   pmem_read     : memory read strobe, held until pmem_resp
//   pmem_write    : memory write strobe, held until pmem_resp
//   pmem_address  : latched transaction address
//   pmem_wdata    : latched transaction write data
//   pmem_rdata    : memory read data
//   pmem_resp     : memory completion pulse

module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               op_write_q;
  logic               read_q;
  logic               write_q;

  logic               d_req;
  logic               grant_d;
  logic               grant_i;

  // Any D-cache request; read and write together is treated as a write.
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  // 1 = D-cache was granted last.
  logic last_grant_d;

  // On a tie, hand the port to the client that did not have it last.
  assign grant_d = d_req & (~i_read | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b1;
    end else if ((state == IDLE) && (grant_d || i_read)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  // Fixed priority: D-cache always wins a tie.
  assign grant_d = d_req;
`endif

  assign grant_i = i_read & ~grant_d;

  // Arbitration FSM with registered memory strobes and latched transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          if (grant_d) begin
            state      <= SERVE_D;
            addr_q     <= d_address;
            wdata_q    <= d_wdata;
            op_write_q <= d_write;
            read_q     <= ~d_write;
            write_q    <= d_write;
          end else if (grant_i) begin
            state      <= SERVE_I;
            addr_q     <= i_address;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            read_q     <= 1'b1;
            write_q    <= 1'b0;
          end
        end

        // Strobe stays up until memory completes; the request level is not
        // re-examined, so a dropped request still finishes its transaction.
        SERVE_I, SERVE_D: begin
          read_q  <= ~op_write_q;
          write_q <= op_write_q;
          if (pmem_resp) begin
            state   <= RELEASE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end

        // One dead cycle so the client can drop its request before the
        // next arbitration.
        RELEASE: begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion is steered to the granted client only; a stray pmem_resp
  // outside SERVE_* produces nothing.
  assign i_resp = (state == SERVE_I) & pmem_resp;
  assign d_resp = (state == SERVE_D) & pmem_resp;

  // Read data is broadcast; only the client receiving resp consumes it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (default build, fixed D-over-I
// priority). Inputs change and outputs are sampled 2 ns after each rising edge.

module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  localparam logic [LINE_W-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_DB = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] LINE_5A = {32{8'h5A}};
  localparam logic [LINE_W-1:0] LINE_3C = {32{8'h3C}};

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst        = 1'b1;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_pmem_read",  LINE_W'(pmem_read), '0);
    check("rst_pmem_write", LINE_W'(pmem_write), '0);
    check("rst_i_resp",     LINE_W'(i_resp), '0);
    check("rst_d_resp",     LINE_W'(d_resp), '0);
    check("rst_pmem_addr",  LINE_W'(pmem_address), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_i_rdata",    i_rdata, '0);
    rst = 1'b0;
    tick();

    // Single I read, memory answers on the 5th strobe cycle
    i_read    = 1'b1;
    i_address = 32'h0000_0100;
    tick();
    check("i_strobe",     LINE_W'(pmem_read), LINE_W'(1));
    check("i_addr",       LINE_W'(pmem_address), LINE_W'(32'h100));
    check("i_no_write",   LINE_W'(pmem_write), '0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("i_strobe_held", LINE_W'(pmem_read), LINE_W'(1));
      check("i_resp_early",  LINE_W'(i_resp), '0);
    end
    pmem_rdata = LINE_A5;
    pmem_resp  = 1'b1;
    #1;
    check("i_resp_pulse", LINE_W'(i_resp), LINE_W'(1));
    check("i_rdata",      i_rdata, LINE_A5);
    check("i_d_resp_0",   LINE_W'(d_resp), '0);
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    #1;
    check("i_release_strobe", LINE_W'(pmem_read), '0);
    check("i_resp_one_cycle", LINE_W'(i_resp), '0);
    tick();
    check("i_idle_no_restrobe", LINE_W'(pmem_read | pmem_write), '0);

    // D writeback issued the moment the arbiter is back in IDLE
    d_write   = 1'b1;
    d_address = 32'h0000_2040;
    d_wdata   = LINE_DB;
    tick();
    check("d_wr_strobe",  LINE_W'(pmem_write), LINE_W'(1));
    check("d_wr_no_read", LINE_W'(pmem_read), '0);
    check("d_wr_addr",    LINE_W'(pmem_address), LINE_W'(32'h2040));
    check("d_wr_wdata",   pmem_wdata, LINE_DB);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("d_wr_held",  LINE_W'(pmem_write), LINE_W'(1));
      check("d_wr_wdata_held", pmem_wdata, LINE_DB);
    end
    pmem_resp = 1'b1;
    #1;
    check("d_wr_resp",      LINE_W'(d_resp), LINE_W'(1));
    check("d_wr_i_resp_0",  LINE_W'(i_resp), '0);
    tick();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    #1;
    check("d_wr_resp_one_cycle", LINE_W'(d_resp), '0);
    check("d_wr_release",        LINE_W'(pmem_write), '0);
    tick();

    // Simultaneous I and D reads, 3-cycle memory: D first, then I
    i_read    = 1'b1;
    i_address = 32'h0000_0300;
    d_read    = 1'b1;
    d_address = 32'h0000_0400;
    tick();
    check("sim_d_first_strobe", LINE_W'(pmem_read), LINE_W'(1));
    check("sim_d_first_addr",   LINE_W'(pmem_address), LINE_W'(32'h400));
    check("sim_d_read_op",      LINE_W'(pmem_write), '0);
    tick();
    tick();
    pmem_rdata = LINE_5A;
    pmem_resp  = 1'b1;
    #1;
    check("sim_d_resp",   LINE_W'(d_resp), LINE_W'(1));
    check("sim_d_i_resp", LINE_W'(i_resp), '0);
    check("sim_d_rdata",  d_rdata, LINE_5A);
    tick();
    pmem_resp = 1'b0;
    d_read    = 1'b0;
    #1;
    check("sim_release", LINE_W'(pmem_read), '0);
    tick();
    check("sim_idle",    LINE_W'(pmem_read), '0);
    tick();
    check("sim_i_strobe", LINE_W'(pmem_read), LINE_W'(1));
    check("sim_i_addr",   LINE_W'(pmem_address), LINE_W'(32'h300));
    tick();
    tick();
    pmem_rdata = LINE_3C;
    pmem_resp  = 1'b1;
    #1;
    check("sim_i_resp",   LINE_W'(i_resp), LINE_W'(1));
    check("sim_i_d_resp", LINE_W'(d_resp), '0);
    check("sim_i_rdata",  i_rdata, LINE_3C);
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    tick();

    // Read+write together is a write; dropping the request mid-flight
    // does not abort the transaction
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0600;
    tick();
    check("rw_is_write", LINE_W'(pmem_write), LINE_W'(1));
    check("rw_no_read",  LINE_W'(pmem_read), '0);
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();
    check("drop_strobe_held", LINE_W'(pmem_write), LINE_W'(1));
    pmem_resp = 1'b1;
    #1;
    check("drop_resp_pulses", LINE_W'(d_resp), LINE_W'(1));
    tick();
    pmem_resp = 1'b0;
    tick();

    // Reset in the 3rd cycle of SERVE_D, then a late pmem_resp
    d_write   = 1'b1;
    d_address = 32'h0000_5000;
    tick();
    check("rst_mid_strobe", LINE_W'(pmem_write), LINE_W'(1));
    tick();
    tick();
    rst     = 1'b1;
    d_write = 1'b0;
    tick();
    check("rst_mid_write_0", LINE_W'(pmem_write), '0);
    check("rst_mid_read_0",  LINE_W'(pmem_read), '0);
    check("rst_mid_addr_0",  LINE_W'(pmem_address), '0);
    rst       = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check("late_resp_d", LINE_W'(d_resp), '0);
    check("late_resp_i", LINE_W'(i_resp), '0);
    tick();

    // Stray pmem_resp in IDLE: no pulses, state stays IDLE
    #1;
    check("stray_d_resp", LINE_W'(d_resp), '0);
    check("stray_i_resp", LINE_W'(i_resp), '0);
    check("stray_no_strobe", LINE_W'(pmem_read | pmem_write), '0);
    pmem_resp = 1'b0;
    i_read    = 1'b1;
    i_address = 32'h0000_0700;
    tick();
    check("post_stray_strobe", LINE_W'(pmem_read), LINE_W'(1));
    check("post_stray_addr",   LINE_W'(pmem_address), LINE_W'(32'h700));
    pmem_resp = 1'b1;
    #1;
    check("post_stray_resp", LINE_W'(i_resp), LINE_W'(1));
    tick();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-client arbiter for the CPU's single physical memory port (one cacheline per transaction).
- I-cache client issues line reads only; D-cache client issues line reads and writebacks.
- Grants one client at a time, latches the address, and runs exactly one memory transaction per grant.
- Routes the response back to the granted client only.

Parameters:
- ADDR_W, 32, address width on all address ports.
- LINE_W, 256, cacheline data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_read  in  1  I-cache line read request; level, held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; level, held until d_resp.
- d_write  in  1  D-cache writeback request; level, held until d_resp.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- Reset values:
  - State is IDLE.
  - pmem_read, pmem_write, i_resp, d_resp are 0.
  - Latched address, latched wdata and latched op are 0.
- IDLE:
  - Samples requests at each edge.
  - If any D request is pending, the D client wins (fixed priority; see Optional Feature).
  - Else if i_read is pending, the I client wins.
  - On grant: latch address, wdata and op (read or write); go to SERVE_x.
  - No pmem strobe is asserted in IDLE.
- SERVE_I / SERVE_D:
  - pmem_read or pmem_write is driven from the latched op, held continuously until pmem_resp.
  - pmem_address and pmem_wdata are driven from the latched values.
  - d_read and d_write both high is treated as a write.
  - When pmem_resp=1:
    - The granted client's resp is asserted in that same cycle.
    - rdata passes combinationally from pmem_rdata.
    - Next state is RELEASE.
- RELEASE:
  - Exactly one cycle; no strobes; no grant. This lets the client drop its request before re-arbitration.
  - Then go to IDLE.
- Latency: request seen at edge N → pmem strobe in cycle N+1 → client resp in the same cycle as pmem_resp.
  - Back-to-back turnaround is 2 idle cycles (RELEASE, IDLE).
- Non-granted client outputs:
  - resp is 0.
  - rdata carries pmem_rdata; it is don't-care, but must not be X under reset.
- pmem_resp outside SERVE_* is ignored.
- rst in any state returns to IDLE at the next edge and drops strobes. Any in-flight memory transaction is abandoned; memory is reset alongside.
- A request that drops before its resp (protocol violation) does not abort the transaction. The transaction completes and resp still pulses.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register, reset to D.
  - On simultaneous I and D requests in IDLE, the client not granted last wins.
  - last_grant updates at each grant.
- Undefined: fixed D-over-I priority; no extra state.

Test Plan:
- Single I read:
  - Stimulus: i_read=1, i_address=0x0000_0100; memory responds after 5 cycles with rdata=0xA5…A5.
  - Required: pmem_read=1, pmem_address=0x100 from cycle 1; i_resp pulse coincides with pmem_resp; i_rdata=0xA5…A5; d_resp stays 0.
- D writeback:
  - Stimulus: d_write=1, d_address=0x0000_2040, d_wdata=0xDEAD…BEEF.
  - Required: pmem_write=1, pmem_address=0x2040, pmem_wdata matches until pmem_resp; d_resp pulses for 1 cycle; pmem_read stays 0.
- Simultaneous requests:
  - Stimulus: i_read and d_read both asserted in cycle 0; each memory transaction takes 3 cycles.
  - Required without MEM_ARB_RR_EN: D served first, then I after RELEASE + IDLE.
  - Required with MEM_ARB_RR_EN: a second simultaneous pair is served I-first.
- Stale-request guard:
  - Stimulus: the client deasserts its request in the cycle after its resp.
  - Required: no second pmem strobe; arbiter is back in IDLE 2 cycles after resp.
- Reset mid-transaction:
  - Stimulus: rst=1 in cycle 3 of SERVE_D, then pmem_resp=1 arrives after reset.
  - Required: strobes are 0 at the next edge; the late pmem_resp produces no d_resp or i_resp.
- Stray pmem_resp:
  - Stimulus: pmem_resp=1 while in IDLE.
  - Required: no resp pulse on either client; state unchanged.
